// File: rtl/forwarding_scoreboard.sv
// Forwarding-select and hazard unit with its own EXE..WB destination tracker.
// Optional stall counter output enabled by define FWD_STALL_COUNT_EN.
module forwarding_scoreboard #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       forward_en_i,
   input  logic                       freeze_i,
   input  logic                       flush_i,
   input  logic                       id_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0]  id_src_i,
   input  logic [NUM_SRC-1:0]         id_src_used_i,
   input  logic                       id_wb_en_i,
   input  logic                       id_mem_read_i,
   input  logic [ADDR_W-1:0]          id_dst_i,
   output logic [NUM_SRC*SEL_W-1:0]   sel_src_o,
   output logic                       hazard_o
`ifdef FWD_STALL_COUNT_EN
   ,
   output logic [15:0]                stall_cycles_o
`endif
);

   logic [DEPTH:0]                valid_q, valid_d;
   logic [DEPTH:0]                wb_en_q, wb_en_d;
   logic [DEPTH:0][ADDR_W-1:0]    dst_q, dst_d;
   // mem_read only matters while the load sits in EXE, so older stages drop it
   logic                          mem_read_q, mem_read_d;
   logic [NUM_SRC*ADDR_W-1:0]     src_q, src_d;
   logic [NUM_SRC-1:0]            src_used_q, src_used_d;
   logic                          capture;

   // Operand selects: scan oldest to nearest so the nearest match overwrites.
   always_comb begin
      sel_src_o = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (forward_en_i && valid_q[0] && src_used_q[i]) begin
            for (int unsigned k = DEPTH; k >= 1; k--) begin
               if (valid_q[k] && wb_en_q[k] && (dst_q[k] == src_q[i*ADDR_W +: ADDR_W])) begin
                  sel_src_o[i*SEL_W +: SEL_W] = SEL_W'(k);
               end
            end
         end
      end
   end

   always_comb begin
      hazard_o = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (id_valid_i && id_src_used_i[i]) begin
            if (forward_en_i) begin
               if (valid_q[0] && wb_en_q[0] && mem_read_q &&
                   (dst_q[0] == id_src_i[i*ADDR_W +: ADDR_W])) begin
                  hazard_o = 1'b1;
               end
            end else begin
               // WB stage is excluded: the register file writes before it reads
               for (int unsigned k = 0; k < DEPTH; k++) begin
                  if (valid_q[k] && wb_en_q[k] && (dst_q[k] == id_src_i[i*ADDR_W +: ADDR_W])) begin
                     hazard_o = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign capture = id_valid_i & ~hazard_o & ~flush_i;

   always_comb begin
      valid_d    = valid_q;
      wb_en_d    = wb_en_q;
      dst_d      = dst_q;
      mem_read_d = mem_read_q;
      src_d      = src_q;
      src_used_d = src_used_q;
      if (!freeze_i) begin
         for (int unsigned k = 1; k <= DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            wb_en_d[k] = wb_en_q[k-1];
            dst_d[k]   = dst_q[k-1];
         end
         valid_d[0] = capture;
         wb_en_d[0] = capture & id_wb_en_i;
         mem_read_d = capture & id_mem_read_i;
         dst_d[0]   = capture ? id_dst_i : '0;
         src_d      = capture ? id_src_i : '0;
         src_used_d = capture ? id_src_used_i : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         wb_en_q    <= '0;
         dst_q      <= '0;
         mem_read_q <= 1'b0;
         src_q      <= '0;
         src_used_q <= '0;
      end else begin
         valid_q    <= valid_d;
         wb_en_q    <= wb_en_d;
         dst_q      <= dst_d;
         mem_read_q <= mem_read_d;
         src_q      <= src_d;
         src_used_q <= src_used_d;
      end
   end

`ifdef FWD_STALL_COUNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard_o && !freeze_i && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
`endif

endmodule
